// File: rtl/sc_distancetickgen.sv
// rtl/sc_distancetickgen.sv - distance accumulator and count/level-end strobe generator
//
// Purpose: turns per-frame car speed into distance, emits an active-low
// one-cycle count strobe every TICK_THRESHOLD units of distance, tracks
// progress within a level and the level index, and raises the level-end
// strobe and the game-over flag.
//
// Optional feature macro: SC_DISTANCETICKGEN_PAUSE_EN (adds the Pause_in port).
//
// Ports:
//   SC_DISTANCETICKGEN_CLOCK_50         in   system clock, rising edge
//   SC_DISTANCETICKGEN_RESET_InHigh     in   synchronous active-high reset
//   SC_DISTANCETICKGEN_Run_in           in   1 = game active, 0 = clear to IDLE
//   SC_DISTANCETICKGEN_Frame_in         in   one-cycle game-update strobe
//   SC_DISTANCETICKGEN_Speed_InBus      in   car speed, sampled on Frame_in
//   SC_DISTANCETICKGEN_Pause_in         in   freeze accumulation (PAUSE_EN only)
//   SC_DISTANCETICKGEN_CountSignal_Out  out  active-low one-cycle count strobe
//   SC_DISTANCETICKGEN_LevelFinished_Out out active-low one-cycle level-end strobe
//   SC_DISTANCETICKGEN_Progress_OutBus  out  ticks counted in current level
//   SC_DISTANCETICKGEN_Level_OutBus     out  current level index, 0-based
//   SC_DISTANCETICKGEN_Done_Out         out  1 while in GAMEOVER

module sc_distancetickgen #(
  parameter int SPEED_WIDTH    = 4,
  parameter int ACC_WIDTH      = 8,
  parameter int TICK_THRESHOLD = 64,
  parameter int PROGRESS_MAX   = 31,
  parameter int NUM_LEVELS     = 3
) (
  input  logic                   SC_DISTANCETICKGEN_CLOCK_50,
  input  logic                   SC_DISTANCETICKGEN_RESET_InHigh,
  input  logic                   SC_DISTANCETICKGEN_Run_in,
  input  logic                   SC_DISTANCETICKGEN_Frame_in,
  input  logic [SPEED_WIDTH-1:0] SC_DISTANCETICKGEN_Speed_InBus,
`ifdef SC_DISTANCETICKGEN_PAUSE_EN
  input  logic                   SC_DISTANCETICKGEN_Pause_in,
`endif
  output logic                   SC_DISTANCETICKGEN_CountSignal_Out,
  output logic                   SC_DISTANCETICKGEN_LevelFinished_Out,
  output logic [4:0]             SC_DISTANCETICKGEN_Progress_OutBus,
  output logic [2:0]             SC_DISTANCETICKGEN_Level_OutBus,
  output logic                   SC_DISTANCETICKGEN_Done_Out
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_FINISH   = 2'd2,
    S_GAMEOVER = 2'd3
  } state_t;

  localparam logic [ACC_WIDTH:0] THRESH     = (ACC_WIDTH+1)'(TICK_THRESHOLD);
  localparam logic [4:0]         PROG_MAX   = 5'(PROGRESS_MAX);
  localparam logic [2:0]         LAST_LEVEL = 3'(NUM_LEVELS - 1);

  logic                 clk, rst, run, frame, pause;
  logic [SPEED_WIDTH-1:0] speed;

  assign clk   = SC_DISTANCETICKGEN_CLOCK_50;
  assign rst   = SC_DISTANCETICKGEN_RESET_InHigh;
  assign run   = SC_DISTANCETICKGEN_Run_in;
  assign frame = SC_DISTANCETICKGEN_Frame_in;
  assign speed = SC_DISTANCETICKGEN_Speed_InBus;
`ifdef SC_DISTANCETICKGEN_PAUSE_EN
  assign pause = SC_DISTANCETICKGEN_Pause_in;
`else
  assign pause = 1'b0;
`endif

  state_t               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [4:0]           prog_q, prog_d;
  logic [2:0]           level_q, level_d;
  logic                 cnt_n_q, cnt_n_d;
  logic                 lf_n_q, lf_n_d;
  logic                 done_q, done_d;

  logic [ACC_WIDTH:0]   sum, diff;

  assign sum  = {1'b0, acc_q} + (ACC_WIDTH+1)'(speed);
  assign diff = sum - THRESH;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. RUN leaves for FINISH one cycle after the last count
  // strobe, so the level-end strobe follows the count strobe without overlap.
  always_comb begin
    state_d = state_q;
    if (!run) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:     state_d = S_RUN;
        S_RUN:      if (prog_q == PROG_MAX) state_d = S_FINISH;
        S_FINISH:   state_d = (level_q == LAST_LEVEL) ? S_GAMEOVER : S_RUN;
        S_GAMEOVER: state_d = S_GAMEOVER;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  // Output / datapath next values. Strobes default to idle-high so each low
  // pulse lasts exactly one cycle.
  always_comb begin
    acc_d   = acc_q;
    prog_d  = prog_q;
    level_d = level_q;
    cnt_n_d = 1'b1;
    lf_n_d  = 1'b1;
    done_d  = (state_d == S_GAMEOVER);
    if (!run) begin
      acc_d   = '0;
      prog_d  = '0;
      level_d = '0;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (prog_q == PROG_MAX) begin
            // Level complete: any frame this cycle is dropped.
            lf_n_d = 1'b0;
          end else if (frame && !pause) begin
            if (sum >= THRESH) begin
              acc_d   = diff[ACC_WIDTH-1:0];
              cnt_n_d = 1'b0;
              prog_d  = prog_q + 5'd1;
            end else begin
              acc_d = sum[ACC_WIDTH-1:0];
            end
          end
        end
        S_FINISH: begin
          acc_d   = '0;
          prog_d  = '0;
          level_d = level_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      prog_q  <= '0;
      level_q <= '0;
      cnt_n_q <= 1'b1;
      lf_n_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      prog_q  <= prog_d;
      level_q <= level_d;
      cnt_n_q <= cnt_n_d;
      lf_n_q  <= lf_n_d;
      done_q  <= done_d;
    end
  end

  assign SC_DISTANCETICKGEN_CountSignal_Out   = cnt_n_q;
  assign SC_DISTANCETICKGEN_LevelFinished_Out = lf_n_q;
  assign SC_DISTANCETICKGEN_Progress_OutBus   = prog_q;
  assign SC_DISTANCETICKGEN_Level_OutBus      = level_q;
  assign SC_DISTANCETICKGEN_Done_Out          = done_q;

endmodule

// File: tb/tb_sc_distancetickgen.sv
// tb/tb_sc_distancetickgen.sv - scoreboard testbench for sc_distancetickgen
module tb_sc_distancetickgen;

  logic       clk = 1'b0;
  logic       rst, run, frame, pause;
  logic [3:0] speed;
  logic       cnt_o, lf_o, done_o;
  logic [4:0] prog_o;
  logic [2:0] lvl_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sc_distancetickgen dut (
    .SC_DISTANCETICKGEN_CLOCK_50         (clk),
    .SC_DISTANCETICKGEN_RESET_InHigh     (rst),
    .SC_DISTANCETICKGEN_Run_in           (run),
    .SC_DISTANCETICKGEN_Frame_in         (frame),
    .SC_DISTANCETICKGEN_Speed_InBus      (speed),
`ifdef SC_DISTANCETICKGEN_PAUSE_EN
    .SC_DISTANCETICKGEN_Pause_in         (pause),
`endif
    .SC_DISTANCETICKGEN_CountSignal_Out  (cnt_o),
    .SC_DISTANCETICKGEN_LevelFinished_Out(lf_o),
    .SC_DISTANCETICKGEN_Progress_OutBus  (prog_o),
    .SC_DISTANCETICKGEN_Level_OutBus     (lvl_o),
    .SC_DISTANCETICKGEN_Done_Out         (done_o)
  );

  // Reference model state (0 idle, 1 run, 2 finish, 3 gameover)
  int         m_st;
  int         m_acc;
  logic [4:0] m_prog;
  logic [2:0] m_lvl;
  logic       m_cnt, m_lf, m_done;

  // Expected {cnt, lf, prog, lvl, done} after each clock edge
  logic [10:0] exp_q[$];
  logic [10:0] e, got;

  task automatic drive(input logic r, input logic rn, input logic fr,
                       input logic [3:0] sp, input logic ps);
    int s;
    logic p;
    rst = r; run = rn; frame = fr; speed = sp; pause = ps;
`ifdef SC_DISTANCETICKGEN_PAUSE_EN
    p = ps;
`else
    p = 1'b0;
`endif
    if (r || !rn) begin
      m_st = 0; m_acc = 0; m_prog = 0; m_lvl = 0;
      m_cnt = 1; m_lf = 1; m_done = 0;
    end else begin
      m_cnt = 1; m_lf = 1;
      case (m_st)
        0: m_st = 1;
        1: begin
          if (m_prog == 5'd31) begin
            m_st = 2; m_lf = 0;
          end else if (fr && !p) begin
            s = m_acc + int'(sp);
            if (s >= 64) begin
              m_acc = s - 64; m_cnt = 0; m_prog = m_prog + 5'd1;
            end else begin
              m_acc = s;
            end
          end
        end
        2: begin
          m_acc = 0; m_prog = 0; m_lvl = m_lvl + 3'd1;
          if (m_lvl == 3'd3) begin m_st = 3; m_done = 1; end
          else m_st = 1;
        end
        default: ;
      endcase
    end
    exp_q.push_back({m_cnt, m_lf, m_prog, m_lvl, m_done});
    @(posedge clk);
    @(negedge clk);
    got = {cnt_o, lf_o, prog_o, lvl_o, done_o};
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      drive(i < 2, 1'b0, i >= 2, 4'd15, 1'b0);
      e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL reset cyc%0d got %h exp %h", i, got, e); end
    end
  endtask

  task automatic test_speed8();
    int ticks = 0;
    drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    e = exp_q.pop_front(); checks++;
    if (got !== e) begin errors++; $display("FAIL speed8_start got %h exp %h", got, e); end
    for (int f = 0; f < 24; f++) begin
      for (int k = 0; k < 4; k++) begin
        drive(1'b0, 1'b1, k == 0, 4'd8, 1'b0);
        if (cnt_o === 1'b0) ticks++;
        e = exp_q.pop_front(); checks++;
        if (got !== e) begin errors++; $display("FAIL speed8 f%0d k%0d got %h exp %h", f, k, got, e); end
      end
    end
    checks++;
    if (ticks != 3 || prog_o !== 5'd3) begin
      errors++; $display("FAIL speed8_total ticks %0d prog %0d exp 3 3", ticks, prog_o);
    end
  endtask

  task automatic test_speed15();
    int ticks = 0;
    drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    void'(exp_q.pop_front());
    drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    void'(exp_q.pop_front());
    // 5 frames tick once (acc 11), then 4 more reach 71 and tick again
    for (int i = 0; i < 11; i++) begin
      drive(1'b0, 1'b1, (i < 5) || (i >= 6 && i < 10), 4'd15, 1'b0);
      if (cnt_o === 1'b0) ticks++;
      e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL speed15 cyc%0d got %h exp %h", i, got, e); end
    end
    checks++;
    if (ticks != 2) begin errors++; $display("FAIL speed15_ticks got %0d exp 2", ticks); end
  endtask

  task automatic test_levels();
    int lfs = 0;
    int n = 0;
    drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    void'(exp_q.pop_front());
    drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    void'(exp_q.pop_front());
    while (done_o !== 1'b1 && n < 2000) begin
      drive(1'b0, 1'b1, 1'b1, 4'd15, 1'b0);
      n++;
      if (lf_o === 1'b0) lfs++;
      e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL levels cyc%0d got %h exp %h", n, got, e); end
    end
    checks++;
    if (done_o !== 1'b1 || lfs != 3) begin
      errors++; $display("FAIL levels_done done %b lf_strobes %0d exp 1 3", done_o, lfs);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 1'b1, 4'd15, 1'b0);
      e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL gameover cyc%0d got %h exp %h", i, got, e); end
    end
    drive(1'b0, 1'b0, 1'b1, 4'd15, 1'b0);
    e = exp_q.pop_front(); checks++;
    if (got !== e || done_o !== 1'b0 || lvl_o !== 3'd0) begin
      errors++; $display("FAIL gameover_exit got %h exp %h", got, e);
    end
  endtask

  task automatic test_abort();
    int n = 0;
    int ticks = 0;
    drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    void'(exp_q.pop_front());
    while (prog_o !== 5'd12 && n < 200) begin
      drive(1'b0, 1'b1, 1'b1, 4'd15, 1'b0);
      n++;
      e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL abort_fill cyc%0d got %h exp %h", n, got, e); end
    end
    drive(1'b0, 1'b0, 1'b1, 4'd15, 1'b0);
    e = exp_q.pop_front(); checks++;
    if (got !== e || prog_o !== 5'd0) begin errors++; $display("FAIL abort_clear got %h exp %h", got, e); end
    drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    void'(exp_q.pop_front());
    // acc cleared: 4 frames of 15 stay below 64, the 5th ticks
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, i < 5, 4'd15, 1'b0);
      if (cnt_o === 1'b0) ticks++;
      e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL abort_acc cyc%0d got %h exp %h", i, got, e); end
    end
    checks++;
    if (ticks != 1 || prog_o !== 5'd1) begin
      errors++; $display("FAIL abort_ticks ticks %0d prog %0d exp 1 1", ticks, prog_o);
    end
  endtask

`ifdef SC_DISTANCETICKGEN_PAUSE_EN
  task automatic test_pause();
    logic [4:0] held;
    drive(1'b0, 1'b1, 1'b1, 4'd15, 1'b0);
    void'(exp_q.pop_front());
    held = prog_o;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 1'b1, 4'd15, 1'b1);
      e = exp_q.pop_front(); checks++;
      if (got !== e || prog_o !== held) begin errors++; $display("FAIL pause cyc%0d got %h exp %h", i, got, e); end
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 1'b1, 4'd15, 1'b0);
      e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL pause_resume cyc%0d got %h exp %h", i, got, e); end
    end
  endtask
`endif

  initial begin
    rst = 1'b1; run = 1'b0; frame = 1'b0; speed = '0; pause = 1'b0;
    @(negedge clk);
    test_reset();
    test_speed8();
    test_speed15();
    test_levels();
    test_abort();
`ifdef SC_DISTANCETICKGEN_PAUSE_EN
    test_pause();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
